// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's bus signals: the instruction memory
// request/response channel, the decode valid/ready channel and the
// branch/jump redirect input. The fetch unit takes the master side and
// memory, decode and branch resolution together take the slave side.
interface instr_fetch_unit_if;

   // Instruction memory channel
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   // Decode channel
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [6:0]  opcode;
   logic [31:0] instr_pc;

   // Redirect from branch/jump resolution
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rvalid,
      input  imem_rdata,
      output instr_valid,
      input  instr_ready,
      output instruction,
      output opcode,
      output instr_pc,
      input  redirect_valid,
      input  redirect_pc
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rvalid,
      output imem_rdata,
      input  instr_valid,
      output instr_ready,
      input  instruction,
      input  opcode,
      input  instr_pc,
      output redirect_valid,
      output redirect_pc
   );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. Owns the program counter, keeps one request
// outstanding to instruction memory at a time, latches the returned word
// into an instruction register and offers it to decode. A redirect from
// branch/jump resolution retargets the PC; a fetch already in flight is
// allowed to complete but its data is thrown away.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_INC   = 4
) (
   input logic              clk,
   input logic              rst_n,
   instr_fetch_unit_if.master bus
);

   // The two low PC bits never reach memory, so force alignment here
   // rather than trusting every caller of the parameter.
   localparam logic [31:0] RESET_PC_W = RESET_PC & ~32'h3;
   localparam logic [31:0] PC_STEP    = 32'(PC_INC);

   // FETCH: request outstanding, waiting for its response.
   // KILL : request outstanding but squashed; its response is dropped.
   // HOLD : instruction register is live and offered to decode.
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      KILL  = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] req_addr_q;
   logic        req_q;
   logic        valid_q;
   logic [31:0] instr_q;
   logic [6:0]  opcode_q;
   logic [31:0] instr_pc_q;

   logic [31:0] target_d;
   logic [31:0] seq_pc_d;

   // Redirect targets are word addresses; the low two bits are dropped.
   assign target_d = bus.redirect_pc & ~32'h3;
   // Sequential successor of the current PC, wrapping modulo 2^32.
   assign seq_pc_d = pc_q + PC_STEP;

   // Fetch controller: state, PC, request and instruction register.
   // req_q resets low so no request is visible while reset is asserted;
   // it rises on the first clock edge after release. Responses that
   // arrive while req_q is low (just after reset, or in HOLD) are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC_W;
         req_addr_q <= RESET_PC_W;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         instr_q    <= 32'h0;
         opcode_q   <= 7'h0;
         instr_pc_q <= 32'h0;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (!req_q) begin
                  // First cycle after reset: nothing is outstanding yet,
                  // so a redirect simply retargets the first request.
                  req_q <= 1'b1;
                  if (bus.redirect_valid) begin
                     pc_q       <= target_d;
                     req_addr_q <= target_d;
                  end
               end else if (bus.imem_rvalid && bus.redirect_valid) begin
                  // Response and redirect together: the response closes
                  // the old request, so the target goes out immediately.
                  pc_q       <= target_d;
                  req_addr_q <= target_d;
               end else if (bus.imem_rvalid) begin
                  instr_q    <= bus.imem_rdata;
                  opcode_q   <= bus.imem_rdata[6:0];
                  instr_pc_q <= req_addr_q;
                  valid_q    <= 1'b1;
                  req_q      <= 1'b0;
                  state_q    <= HOLD;
               end else if (bus.redirect_valid) begin
                  // The old address must stay on the bus until its
                  // response arrives, so only pc moves.
                  pc_q    <= target_d;
                  state_q <= KILL;
               end
            end

            KILL: begin
               if (bus.imem_rvalid) begin
                  state_q <= FETCH;
                  if (bus.redirect_valid) begin
                     pc_q       <= target_d;
                     req_addr_q <= target_d;
                  end else begin
                     req_addr_q <= pc_q;
                  end
               end else if (bus.redirect_valid) begin
                  pc_q <= target_d;
               end
            end

            HOLD: begin
               if (bus.redirect_valid) begin
                  // Redirect outranks consumption: no sequential step.
                  pc_q       <= target_d;
                  req_addr_q <= target_d;
                  valid_q    <= 1'b0;
                  req_q      <= 1'b1;
                  state_q    <= FETCH;
               end else if (bus.instr_ready) begin
                  pc_q       <= seq_pc_d;
                  req_addr_q <= seq_pc_d;
                  valid_q    <= 1'b0;
                  req_q      <= 1'b1;
                  state_q    <= FETCH;
               end
            end

            default: begin
               state_q <= FETCH;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = req_addr_q;
   assign bus.instr_valid = valid_q;
   assign bus.instruction = instr_q;
   assign bus.opcode      = opcode_q;
   assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by a
// randomized phase checked against a program-order reference model.
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk;
   logic rst_n;

   instr_fetch_unit_if bus ();

   instr_fetch_unit #(
      .RESET_PC (RESET_PC),
      .PC_INC   (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   checks = 0;
   int   errors = 0;
   int   memLat = 0;
   logic injectRvalid = 1'b0;
   logic monEn = 1'b0;

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Contents of instruction memory; address 0 holds addi x1,x0,5.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkFlag(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
      bus.instr_ready    = rdy;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      step();
      bus.redirect_valid = 1'b0;
   endtask

   task automatic applyReset();
      rst_n              = 1'b0;
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic waitValid(input string tag);
      int n = 0;
      while (bus.instr_valid !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      checkFlag(tag, bus.instr_valid, 1'b1);
   endtask

   // Memory responder: one response per accepted request after memLat
   // wait cycles; can also inject a spurious response on demand.
   initial begin : responder
      logic busy;
      logic realResp;
      int   cnt;
      busy = 1'b0;
      realResp = 1'b0;
      cnt = 0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (realResp) busy = 1'b0;
         realResp = 1'b0;
         bus.imem_rvalid = 1'b0;
         if (!rst_n) busy = 1'b0;
         if (injectRvalid) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
         end else if (rst_n) begin
            if (bus.imem_req && !busy) begin
               busy = 1'b1;
               cnt  = memLat;
            end
            if (busy) begin
               if (cnt == 0) begin
                  bus.imem_rvalid = 1'b1;
                  bus.imem_rdata  = memWord(bus.imem_addr);
                  realResp = 1'b1;
               end else begin
                  cnt--;
               end
            end
         end
      end
   end

   // Program-order reference model: tracks which PC decode should see
   // next and checks every presented word, address stability and progress.
   logic [31:0] monExpPc;
   logic [31:0] monWord;
   logic        monPrevReq;
   logic        monPrevRvalid;
   logic [31:0] monPrevAddr;
   int          monIdle;

   always @(negedge clk) begin
      if (!monEn) begin
         monExpPc      = RESET_PC;
         monPrevReq    = 1'b0;
         monPrevRvalid = 1'b0;
         monPrevAddr   = 32'h0;
         monIdle       = 0;
      end else begin
         if (monPrevReq && !monPrevRvalid) begin
            checkFlag("mReqHeld", bus.imem_req, 1'b1);
            checkOutput("mAddrHeld", bus.imem_addr, monPrevAddr);
         end
         if (bus.instr_valid) begin
            monWord = memWord(monExpPc);
            checkOutput("mInstrPc", bus.instr_pc, monExpPc);
            checkOutput("mInstr", bus.instruction, monWord);
            checkOutput("mOpcode", {25'h0, bus.opcode}, {25'h0, monWord[6:0]});
            checkFlag("mNoReqInHold", bus.imem_req, 1'b0);
            monIdle = 0;
         end else begin
            monIdle++;
         end
         checkFlag("mProgress", monIdle > 120, 1'b0);
         if (bus.redirect_valid) monExpPc = bus.redirect_pc & ~32'h3;
         else if (bus.instr_valid && bus.instr_ready) monExpPc = monExpPc + 32'd4;
         monPrevReq    = bus.imem_req;
         monPrevRvalid = bus.imem_rvalid;
         monPrevAddr   = bus.imem_addr;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   // Directed scenarios, then randomized traffic.
   initial begin
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;

      rst_n = 1'b0;
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      step();
      checkFlag("rstReq", bus.imem_req, 1'b0);
      checkFlag("rstValid", bus.instr_valid, 1'b0);
      checkOutput("rstInstr", bus.instruction, 32'h0);
      checkOutput("rstOpcode", {25'h0, bus.opcode}, 32'h0);
      checkOutput("rstPc", bus.instr_pc, 32'h0);

      // Sequential fetch, one-cycle memory, decode always ready.
      $display("[TB] sequential fetch");
      memLat = 1;
      applyReset();
      bus.instr_ready = 1'b1;
      step();
      checkFlag("t1Req0", bus.imem_req, 1'b1);
      checkOutput("t1Addr0", bus.imem_addr, 32'h0);
      step();
      checkFlag("t1NotYet", bus.instr_valid, 1'b0);
      step();
      checkFlag("t1Valid0", bus.instr_valid, 1'b1);
      checkOutput("t1Instr0", bus.instruction, 32'h0050_0093);
      checkOutput("t1Opc0", {25'h0, bus.opcode}, 32'h13);
      checkOutput("t1Pc0", bus.instr_pc, 32'h0);
      step();
      checkFlag("t1Req1", bus.imem_req, 1'b1);
      checkOutput("t1Addr1", bus.imem_addr, 32'h4);
      waitValid("t1Valid1");
      checkOutput("t1Pc1", bus.instr_pc, 32'h4);
      step();
      checkOutput("t1Addr2", bus.imem_addr, 32'h8);

      // Wait states and a decode stall.
      $display("[TB] wait states and stall");
      memLat = 3;
      applyReset();
      step();
      waitValid("t2Valid0");
      applyStimulus(1'b1, 1'b0, 32'h0);
      bus.instr_ready = 1'b0;
      checkOutput("t2Addr", bus.imem_addr, 32'h4);
      for (int i = 0; i < 3; i++) begin
         step();
         checkFlag("t2WaitReq", bus.imem_req, 1'b1);
         checkOutput("t2WaitAddr", bus.imem_addr, 32'h4);
         checkFlag("t2WaitValid", bus.instr_valid, 1'b0);
      end
      step();
      checkFlag("t2Valid", bus.instr_valid, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         checkFlag("t2HoldValid", bus.instr_valid, 1'b1);
         checkOutput("t2HoldInstr", bus.instruction, memWord(32'h4));
         checkOutput("t2HoldPc", bus.instr_pc, 32'h4);
         checkFlag("t2HoldReq", bus.imem_req, 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 32'h0);
      bus.instr_ready = 1'b0;
      checkFlag("t2Drop", bus.instr_valid, 1'b0);
      checkOutput("t2Next", bus.imem_addr, 32'h8);

      // Redirect while a fetch is pending.
      $display("[TB] redirect during fetch");
      memLat = 2;
      applyReset();
      step();
      applyStimulus(1'b0, 1'b1, 32'h100);
      checkOutput("t3KillAddr", bus.imem_addr, 32'h0);
      checkFlag("t3KillValid", bus.instr_valid, 1'b0);
      step();
      checkOutput("t3KillAddrB", bus.imem_addr, 32'h0);
      step();
      checkFlag("t3StaleValid", bus.instr_valid, 1'b0);
      checkOutput("t3NewAddr", bus.imem_addr, 32'h100);
      waitValid("t3Valid");
      checkOutput("t3Pc", bus.instr_pc, 32'h100);
      checkOutput("t3Instr", bus.instruction, memWord(32'h100));

      // Repeated redirects while killing; the last one wins.
      memLat = 2;
      applyReset();
      step();
      applyStimulus(1'b0, 1'b1, 32'h100);
      applyStimulus(1'b0, 1'b1, 32'h180);
      applyStimulus(1'b0, 1'b1, 32'h1C0);
      checkOutput("t3bAddr", bus.imem_addr, 32'h1C0);
      waitValid("t3bValid");
      checkOutput("t3bPc", bus.instr_pc, 32'h1C0);

      // Redirect in HOLD together with instr_ready.
      $display("[TB] redirect during hold");
      memLat = 0;
      applyReset();
      waitValid("t4Valid0");
      applyStimulus(1'b1, 1'b1, 32'h203);
      bus.instr_ready = 1'b0;
      checkFlag("t4Drop", bus.instr_valid, 1'b0);
      checkFlag("t4Req", bus.imem_req, 1'b1);
      checkOutput("t4Addr", bus.imem_addr, 32'h200);
      waitValid("t4Valid1");
      checkOutput("t4Pc", bus.instr_pc, 32'h200);
      checkOutput("t4Instr", bus.instruction, memWord(32'h200));

      // Redirect in the same cycle as the response.
      $display("[TB] redirect with response");
      memLat = 1;
      applyReset();
      step();
      step();
      applyStimulus(1'b0, 1'b1, 32'h340);
      checkFlag("t5Req", bus.imem_req, 1'b1);
      checkOutput("t5Addr", bus.imem_addr, 32'h340);
      checkFlag("t5Valid", bus.instr_valid, 1'b0);
      waitValid("t5Valid1");
      checkOutput("t5Pc", bus.instr_pc, 32'h340);
      checkOutput("t5Instr", bus.instruction, memWord(32'h340));

      // PC wrap at the top of the address space.
      $display("[TB] pc wrap");
      memLat = 0;
      applyReset();
      waitValid("t6Valid0");
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE);
      checkOutput("t6AddrTop", bus.imem_addr, 32'hFFFF_FFFC);
      waitValid("t6Valid1");
      checkOutput("t6PcTop", bus.instr_pc, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 32'h0);
      bus.instr_ready = 1'b0;
      checkOutput("t6Wrap", bus.imem_addr, 32'h0);
      waitValid("t6Valid2");

      // Spurious response in HOLD is ignored.
      injectRvalid = 1'b1;
      step();
      injectRvalid = 1'b0;
      step();
      checkFlag("t7Valid", bus.instr_valid, 1'b1);
      checkOutput("t7Pc", bus.instr_pc, 32'h0);
      checkOutput("t7Instr", bus.instruction, memWord(32'h0));
      checkFlag("t7Req", bus.imem_req, 1'b0);

      // Asynchronous reset from HOLD, with a stray response at release.
      $display("[TB] reset in hold");
      rst_n = 1'b0;
      #1;
      checkFlag("t8Valid", bus.instr_valid, 1'b0);
      checkFlag("t8Req", bus.imem_req, 1'b0);
      checkOutput("t8Instr", bus.instruction, 32'h0);
      checkOutput("t8Pc", bus.instr_pc, 32'h0);
      injectRvalid = 1'b1;
      step();
      rst_n = 1'b1;
      injectRvalid = 1'b0;
      step();
      checkFlag("t8ReqUp", bus.imem_req, 1'b1);
      checkOutput("t8Addr", bus.imem_addr, RESET_PC);
      checkFlag("t8NoStale", bus.instr_valid, 1'b0);
      step();
      checkFlag("t8Valid1", bus.instr_valid, 1'b1);
      checkOutput("t8Instr1", bus.instruction, 32'h0050_0093);

      // Randomized traffic against the reference model.
      $display("[TB] random traffic");
      memLat = 0;
      applyReset();
      monEn = 1'b1;
      for (int i = 0; i < 600; i++) begin
         memLat = $urandom_range(0, 3);
         rdy    = ($urandom_range(0, 3) != 0);
         redir  = ($urandom_range(0, 15) == 0);
         rpc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom();
         applyStimulus(rdy, redir, rpc);
      end
      monEn = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
